mult8_sched: RTL

Sequencer and two-port arbiter for the shared 8-bit stepped multiply unit (`mult_8`). Accepts operand triples (a, b, c) from two requesters. Grants the unit round-robin and drives its activate/clear/operand pins through the fixed step/phase schedule. Captures the low and high result bytes and returns them tagged with the requester ID. Sits between the ALU issue logic and the single `mult_8` instance.

---
 rtl/mult8_sched.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mult8_sched.sv
// Round-robin sequencer for the shared stepped multiply unit (mult_8).
// Optional macro MULT8_SCHED_FIXED_PRIO_EN makes req0 win every tie.
module mult8_sched #(
   parameter int STEPS  = 8,
   parameter int PHASES = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0_valid,
   input  logic       req1_valid,
   output logic       req0_ready,
   output logic       req1_ready,
   input  logic [7:0] req0_a,
   input  logic [7:0] req0_b,
   input  logic [7:0] req0_c,
   input  logic [7:0] req1_a,
   input  logic [7:0] req1_b,
   input  logic [7:0] req1_c,
   output logic       rsp_valid,
   output logic       rsp_id,
   output logic [7:0] rsp_lo,
   output logic [7:0] rsp_hi,
   output logic       busy,
   output logic       mu_activate,
   output logic       mu_clear,
   output logic [7:0] mu_a,
   output logic [7:0] mu_b,
   output logic [7:0] mu_c,
   input  logic [7:0] mu_lo,
   input  logic [7:0] mu_hi
);

   localparam int SW = (STEPS  > 1) ? $clog2(STEPS)  : 1;
   localparam int PW = (PHASES > 1) ? $clog2(PHASES) : 1;
   localparam logic [SW-1:0] STEP_LAST  = SW'(STEPS - 1);
   localparam logic [PW-1:0] PHASE_LAST = PW'(PHASES - 1);

   typedef enum logic [1:0] {IDLE, STEP, RESULT} state_t;

   state_t        state_reg, state_next;
   logic [SW-1:0] step_reg, step_next;
   logic [PW-1:0] phase_reg, phase_next;
   logic [7:0]    a_reg, b_reg, c_reg;
   logic          id_reg;
   logic          rsp_valid_reg, rsp_id_reg;
   logic [7:0]    rsp_lo_reg, rsp_hi_reg;
   logic          grant0, grant1, accept;

`ifdef MULT8_SCHED_FIXED_PRIO_EN
   assign grant0 = req0_valid;
`else
   logic last_grant_reg;

   // A tie goes to whichever requester was not served last.
   assign grant0 = req0_valid && (!req1_valid || last_grant_reg);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         last_grant_reg <= 1'b1;
      else if (accept)
         last_grant_reg <= grant1;
   end
`endif
   assign grant1 = req1_valid && !grant0;

   always_comb begin
      state_next  = state_reg;
      step_next   = step_reg;
      phase_next  = phase_reg;
      req0_ready  = 1'b0;
      req1_ready  = 1'b0;
      accept      = 1'b0;
      mu_clear    = 1'b0;
      mu_activate = 1'b0;
      mu_a        = 8'd0;
      mu_b        = 8'd0;
      mu_c        = 8'd0;
      case (state_reg)
         IDLE: begin
            mu_clear   = 1'b1;
            req0_ready = grant0;
            req1_ready = grant1;
            if (grant0 || grant1) begin
               accept     = 1'b1;
               state_next = STEP;
               step_next  = '0;
               phase_next = '0;
            end
         end
         STEP: begin
            mu_activate = 1'b1;
            if (phase_reg == '0) begin
               mu_a = a_reg;
               mu_b = b_reg;
               mu_c = c_reg;
            end
            if (phase_reg == PHASE_LAST) begin
               phase_next = '0;
               if (step_reg == STEP_LAST)
                  state_next = RESULT;
               else
                  step_next = step_reg + SW'(1);
            end else begin
               phase_next = phase_reg + PW'(1);
            end
         end
         RESULT: begin
            mu_activate = 1'b1;
            state_next  = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
         step_reg  <= '0;
         phase_reg <= '0;
      end else begin
         state_reg <= state_next;
         step_reg  <= step_next;
         phase_reg <= phase_next;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_reg  <= 8'd0;
         b_reg  <= 8'd0;
         c_reg  <= 8'd0;
         id_reg <= 1'b0;
      end else if (accept) begin
         a_reg  <= grant0 ? req0_a : req1_a;
         b_reg  <= grant0 ? req0_b : req1_b;
         c_reg  <= grant0 ? req0_c : req1_c;
         id_reg <= grant1;
      end
   end

   // The unit's result is sampled on the last cycle it is active.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rsp_valid_reg <= 1'b0;
         rsp_id_reg    <= 1'b0;
         rsp_lo_reg    <= 8'd0;
         rsp_hi_reg    <= 8'd0;
      end else begin
         rsp_valid_reg <= (state_reg == RESULT);
         if (state_reg == RESULT) begin
            rsp_id_reg <= id_reg;
            rsp_lo_reg <= mu_lo;
            rsp_hi_reg <= mu_hi;
         end
      end
   end

   assign rsp_valid = rsp_valid_reg;
   assign rsp_id    = rsp_id_reg;
   assign rsp_lo    = rsp_lo_reg;
   assign rsp_hi    = rsp_hi_reg;
   assign busy      = (state_reg != IDLE);

endmodule
